l2_cache_read_stage: RTL and testbench



---
 rtl/l2_cache_pkg.sv | 39 +++
 rtl/l2_cache_read_stage_if.sv | 83 ++++++++
 rtl/l2_sync_reservation.sv | 70 +++++++
 rtl/sram_1r1w.sv | 35 +++
 rtl/l2_cache_read_stage.sv | 146 ++++++++++++++
 tb/tb_l2_cache_read_stage.sv | 277 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/l2_cache_pkg.sv
// ============================================================================
// Module   : l2_cache_pkg
// Purpose  : Shared definitions for the L2 read pipeline: request op codes,
//            default sizing and the set/tag address split helper.
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package l2_cache_pkg;

    localparam int L2_NUM_CORES        = 2;
    localparam int L2_STRANDS_PER_CORE = 4;
    localparam int L2_ADDR_WIDTH       = 26;

    typedef enum logic [2:0] {
        L2REQ_LOAD       = 3'd0,
        L2REQ_STORE      = 3'd1,
        L2REQ_FLUSH      = 3'd2,
        L2REQ_INVALIDATE = 3'd3,
        L2REQ_LOAD_SYNC  = 3'd4,
        L2REQ_STORE_SYNC = 3'd5
    } l2req_op_e;

    // Rebuild a line address from a (zero-extended) tag and the set bits of
    // another address; used to name the victim line of a fill.
    function automatic logic [L2_ADDR_WIDTH-1:0] l2_victim_addr(
        input logic [L2_ADDR_WIDTH-1:0] tag_ext,
        input logic [L2_ADDR_WIDTH-1:0] addr,
        input int unsigned              set_w
    );
        logic [L2_ADDR_WIDTH-1:0] set_mask;
        set_mask = (L2_ADDR_WIDTH'(1) << set_w) - L2_ADDR_WIDTH'(1);
        return (tag_ext << set_w) | (addr & set_mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_cache_read_stage_if.sv
// ============================================================================
// Module   : l2_cache_read_stage_if
// Purpose  : Bundle between directory stage, writeback feedback and the
//            read stage. master = directory/feedback side, slave = read stage.
// Ports    : stall, dir_* request/side-band, wr_* SRAM update, rd_* results
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

interface l2_cache_read_stage_if #(
    parameter int NUM_CORES        = 2,
    parameter int STRANDS_PER_CORE = 4,
    parameter int NUM_WAYS         = 4,
    parameter int SET_WIDTH        = 8,
    parameter int ADDR_WIDTH       = 26,
    parameter int LINE_BITS        = 512,
    parameter int L1_WAY_W         = 2
);
    localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int STRAND_W  = (STRANDS_PER_CORE > 1) ? $clog2(STRANDS_PER_CORE) : 1;
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH;
    localparam int MASK_BITS = LINE_BITS / 8;

    logic                          stall_pipeline;
    logic                          dir_l2req_valid,   rd_l2req_valid;
    logic [CORE_W-1:0]             dir_l2req_core,    rd_l2req_core;
    logic [1:0]                    dir_l2req_unit,    rd_l2req_unit;
    logic [STRAND_W-1:0]           dir_l2req_strand,  rd_l2req_strand;
    logic [2:0]                    dir_l2req_op,      rd_l2req_op;
    logic [1:0]                    dir_l2req_way,     rd_l2req_way;
    logic [ADDR_WIDTH-1:0]         dir_l2req_address, rd_l2req_address;
    logic [LINE_BITS-1:0]          dir_l2req_data,    rd_l2req_data;
    logic [MASK_BITS-1:0]          dir_l2req_mask,    rd_l2req_mask;
    logic                          dir_has_sm_data,   rd_has_sm_data;
    logic [LINE_BITS-1:0]          dir_sm_data,       rd_sm_data;
    logic [WAY_W-1:0]              dir_hit_l2_way,    rd_hit_l2_way;
    logic [WAY_W-1:0]              dir_replace_l2_way, rd_replace_l2_way;
    logic [WAY_W-1:0]              dir_sm_fill_way,   rd_sm_fill_way;
    logic                          dir_cache_hit,     rd_cache_hit;
    logic [TAG_WIDTH-1:0]          dir_old_l2_tag,    rd_old_l2_tag;
    logic [NUM_WAYS-1:0]           dir_l2_dirty,      rd_l2_dirty;
    logic [NUM_CORES-1:0]          dir_l1_has_line,   rd_l1_has_line;
    logic [NUM_CORES*L1_WAY_W-1:0] dir_l1_way,        rd_l1_way;
    logic                          wr_update_l2_data;
    logic [WAY_W+SET_WIDTH-1:0]    wr_cache_write_index;
    logic [LINE_BITS-1:0]          wr_update_data;
    logic [LINE_BITS-1:0]          rd_cache_mem_result;
    logic                          rd_line_is_dirty;
    logic                          rd_store_sync_success;

    modport master (
        output stall_pipeline, dir_l2req_valid, dir_l2req_core, dir_l2req_unit,
               dir_l2req_strand, dir_l2req_op, dir_l2req_way, dir_l2req_address,
               dir_l2req_data, dir_l2req_mask, dir_has_sm_data, dir_sm_data,
               dir_hit_l2_way, dir_replace_l2_way, dir_sm_fill_way, dir_cache_hit,
               dir_old_l2_tag, dir_l2_dirty, dir_l1_has_line, dir_l1_way,
               wr_update_l2_data, wr_cache_write_index, wr_update_data,
        input  rd_l2req_valid, rd_l2req_core, rd_l2req_unit, rd_l2req_strand,
               rd_l2req_op, rd_l2req_way, rd_l2req_address, rd_l2req_data,
               rd_l2req_mask, rd_has_sm_data, rd_sm_data, rd_hit_l2_way,
               rd_replace_l2_way, rd_sm_fill_way, rd_cache_hit, rd_old_l2_tag,
               rd_l2_dirty, rd_l1_has_line, rd_l1_way, rd_cache_mem_result,
               rd_line_is_dirty, rd_store_sync_success
    );

    modport slave (
        input  stall_pipeline, dir_l2req_valid, dir_l2req_core, dir_l2req_unit,
               dir_l2req_strand, dir_l2req_op, dir_l2req_way, dir_l2req_address,
               dir_l2req_data, dir_l2req_mask, dir_has_sm_data, dir_sm_data,
               dir_hit_l2_way, dir_replace_l2_way, dir_sm_fill_way, dir_cache_hit,
               dir_old_l2_tag, dir_l2_dirty, dir_l1_has_line, dir_l1_way,
               wr_update_l2_data, wr_cache_write_index, wr_update_data,
        output rd_l2req_valid, rd_l2req_core, rd_l2req_unit, rd_l2req_strand,
               rd_l2req_op, rd_l2req_way, rd_l2req_address, rd_l2req_data,
               rd_l2req_mask, rd_has_sm_data, rd_sm_data, rd_hit_l2_way,
               rd_replace_l2_way, rd_sm_fill_way, rd_cache_hit, rd_old_l2_tag,
               rd_l2_dirty, rd_l1_has_line, rd_l1_way, rd_cache_mem_result,
               rd_line_is_dirty, rd_store_sync_success
    );
endinterface

`default_nettype wire

// File: rtl/l2_sync_reservation.sv
// ============================================================================
// Module   : l2_sync_reservation
// Purpose  : Per-strand synchronized-load reservation table. LOAD_SYNC sets a
//            reservation, STORE and successful STORE_SYNC clear all entries
//            on the address, a fill clears entries on the victim line.
// Ports    : clk, reset_n; upd_en_i (valid & !stall); core_i/strand_i/op_i/
//            addr_i request; kill_en_i/kill_addr_i victim; success_o (comb.)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module l2_sync_reservation import l2_cache_pkg::*; #(
    parameter int NUM_CORES        = L2_NUM_CORES,
    parameter int STRANDS_PER_CORE = L2_STRANDS_PER_CORE,
    parameter int ADDR_WIDTH       = L2_ADDR_WIDTH,
    parameter int CORE_W           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int STRAND_W         = (STRANDS_PER_CORE > 1) ? $clog2(STRANDS_PER_CORE) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  upd_en_i,
    input  logic [CORE_W-1:0]     core_i,
    input  logic [STRAND_W-1:0]   strand_i,
    input  logic [2:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  kill_en_i,
    input  logic [ADDR_WIDTH-1:0] kill_addr_i,
    output logic                  success_o
);
    localparam int DEPTH = NUM_CORES * STRANDS_PER_CORE;
    localparam int GID_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [GID_W-1:0]                 gid_w;
    logic                             clr_match_w;

    assign gid_w       = GID_W'(int'(core_i) * STRANDS_PER_CORE + int'(strand_i));
    assign success_o   = valid_q[gid_w] && (addr_q[gid_w] == addr_i);
    assign clr_match_w = (op_i == L2REQ_STORE) || ((op_i == L2REQ_STORE_SYNC) && success_o);

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (upd_en_i) begin
            if (op_i == L2REQ_LOAD_SYNC) begin
                valid_d[gid_w] = 1'b1;
                addr_d[gid_w]  = addr_i;
            end
            // Matching against addr_d lets a same-cycle victim kill override
            // a fresh LOAD_SYNC on the evicted line.
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_match_w && (addr_d[i] == addr_i))     valid_d[i] = 1'b0;
                if (kill_en_i   && (addr_d[i] == kill_addr_i)) valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            addr_q  <= '1;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/sram_1r1w.sv
// ============================================================================
// Module   : sram_1r1w
// Purpose  : One-read one-write synchronous SRAM, registered read port.
//            Read-during-write to the same address returns the old data.
//            Contents are not reset.
// Ports    : clk; rd_en_i/rd_addr_i -> rd_data_o; wr_en_i/wr_addr_i/wr_data_i
// Revision : 1.0 - existing macro model
// ============================================================================
`default_nettype none

module sram_1r1w #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

`default_nettype wire

// File: rtl/l2_cache_read_stage.sv
// ============================================================================
// Module   : l2_cache_read_stage
// Purpose  : L2 data-read pipeline stage. Issues the data SRAM read, registers
//            all directory side-band fields (latency 1), selects the victim /
//            flush way dirty bit and evaluates STORE_SYNC reservations.
// Ports    : clk, reset_n (async, active-low); bus (slave): stall, dir_*,
//            wr_* in; rd_* out
// Config   : L2_READ_BYPASS_EN - forward same-cycle write data to a read of
//            the same index (default: old SRAM data is returned)
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module l2_cache_read_stage import l2_cache_pkg::*; #(
    parameter int NUM_CORES        = L2_NUM_CORES,
    parameter int STRANDS_PER_CORE = L2_STRANDS_PER_CORE,
    parameter int NUM_WAYS         = 4,
    parameter int SET_WIDTH        = 8,
    parameter int ADDR_WIDTH       = L2_ADDR_WIDTH,
    parameter int LINE_BITS        = 512,
    parameter int L1_WAY_W         = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    l2_cache_read_stage_if.slave   bus
);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int IDX_W = WAY_W + SET_WIDTH;

    logic                  upd_en_w, sram_we_w, kill_en_w, sync_ok_w;
    logic [WAY_W-1:0]      sel_way_w;
    logic [IDX_W-1:0]      rd_idx_w;
    logic [ADDR_WIDTH-1:0] victim_addr_w;
    logic [LINE_BITS-1:0]  sram_rdata_w, line_data_w;

    assign upd_en_w  = bus.dir_l2req_valid && !bus.stall_pipeline;
    assign sram_we_w = bus.wr_update_l2_data && !bus.stall_pipeline;
    assign rd_idx_w  = {bus.dir_cache_hit ? bus.dir_hit_l2_way : bus.dir_sm_fill_way,
                        bus.dir_l2req_address[SET_WIDTH-1:0]};
    assign sel_way_w = (bus.dir_l2req_op == L2REQ_FLUSH) ? bus.dir_hit_l2_way
                                                         : bus.dir_sm_fill_way;
    assign kill_en_w = !bus.dir_cache_hit && bus.dir_has_sm_data;
    assign victim_addr_w = l2_victim_addr(L2_ADDR_WIDTH'(bus.dir_old_l2_tag),
                                          bus.dir_l2req_address, SET_WIDTH);

    // Read port frozen under stall so the result holds even if the request
    // presented on dir_* changes while the stage is stalled.
    sram_1r1w #(.WIDTH(LINE_BITS), .DEPTH(NUM_WAYS << SET_WIDTH)) u_data_sram (
        .clk       (clk),
        .rd_en_i   (!bus.stall_pipeline),
        .rd_addr_i (rd_idx_w),
        .rd_data_o (sram_rdata_w),
        .wr_en_i   (sram_we_w),
        .wr_addr_i (bus.wr_cache_write_index),
        .wr_data_i (bus.wr_update_data)
    );

    l2_sync_reservation #(
        .NUM_CORES(NUM_CORES), .STRANDS_PER_CORE(STRANDS_PER_CORE), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_resv (
        .clk         (clk),
        .reset_n     (reset_n),
        .upd_en_i    (upd_en_w),
        .core_i      (bus.dir_l2req_core),
        .strand_i    (bus.dir_l2req_strand),
        .op_i        (bus.dir_l2req_op),
        .addr_i      (bus.dir_l2req_address),
        .kill_en_i   (kill_en_w),
        .kill_addr_i (victim_addr_w),
        .success_o   (sync_ok_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_l2req_valid        <= 1'b0;
            bus.rd_l2req_core         <= '0;
            bus.rd_l2req_unit         <= '0;
            bus.rd_l2req_strand       <= '0;
            bus.rd_l2req_op           <= '0;
            bus.rd_l2req_way          <= '0;
            bus.rd_l2req_address      <= '0;
            bus.rd_l2req_data         <= '0;
            bus.rd_l2req_mask         <= '0;
            bus.rd_has_sm_data        <= 1'b0;
            bus.rd_sm_data            <= '0;
            bus.rd_hit_l2_way         <= '0;
            bus.rd_replace_l2_way     <= '0;
            bus.rd_sm_fill_way        <= '0;
            bus.rd_cache_hit          <= 1'b0;
            bus.rd_old_l2_tag         <= '0;
            bus.rd_l2_dirty           <= '0;
            bus.rd_l1_has_line        <= '0;
            bus.rd_l1_way             <= '0;
            bus.rd_line_is_dirty      <= 1'b0;
            bus.rd_store_sync_success <= 1'b0;
        end else if (!bus.stall_pipeline) begin
            bus.rd_l2req_valid        <= bus.dir_l2req_valid;
            bus.rd_l2req_core         <= bus.dir_l2req_core;
            bus.rd_l2req_unit         <= bus.dir_l2req_unit;
            bus.rd_l2req_strand       <= bus.dir_l2req_strand;
            bus.rd_l2req_op           <= bus.dir_l2req_op;
            bus.rd_l2req_way          <= bus.dir_l2req_way;
            bus.rd_l2req_address      <= bus.dir_l2req_address;
            bus.rd_l2req_data         <= bus.dir_l2req_data;
            bus.rd_l2req_mask         <= bus.dir_l2req_mask;
            bus.rd_has_sm_data        <= bus.dir_has_sm_data;
            bus.rd_sm_data            <= bus.dir_sm_data;
            bus.rd_hit_l2_way         <= bus.dir_hit_l2_way;
            bus.rd_replace_l2_way     <= bus.dir_replace_l2_way;
            bus.rd_sm_fill_way        <= bus.dir_sm_fill_way;
            bus.rd_cache_hit          <= bus.dir_cache_hit;
            bus.rd_old_l2_tag         <= bus.dir_old_l2_tag;
            bus.rd_l2_dirty           <= bus.dir_l2_dirty;
            bus.rd_l1_has_line        <= bus.dir_l1_has_line;
            bus.rd_l1_way             <= bus.dir_l1_way;
            bus.rd_line_is_dirty      <= bus.dir_l2_dirty[sel_way_w];
            bus.rd_store_sync_success <= bus.dir_l2req_valid &&
                                         (bus.dir_l2req_op == L2REQ_STORE_SYNC) && sync_ok_w;
        end
    end

`ifdef L2_READ_BYPASS_EN
    logic                 byp_sel_q;
    logic [LINE_BITS-1:0] byp_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
        end else if (!bus.stall_pipeline) begin
            byp_sel_q  <= sram_we_w && (bus.wr_cache_write_index == rd_idx_w);
            byp_data_q <= bus.wr_update_data;
        end
    end

    assign line_data_w = byp_sel_q ? byp_data_q : sram_rdata_w;
`else
    assign line_data_w = sram_rdata_w;
`endif

    // The SRAM read register has no reset; qualifying with the registered
    // valid gives a clean zero result during and after reset.
    assign bus.rd_cache_mem_result = bus.rd_l2req_valid ? line_data_w : '0;
endmodule

`default_nettype wire

// File: tb/tb_l2_cache_read_stage.sv
// ============================================================================
// Module   : tb_l2_cache_read_stage
// Purpose  : Directed + randomized self-checking bench for the L2 read stage,
//            checked against a transaction-level reservation/SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_l2_cache_read_stage;
    localparam logic [2:0] OP_LD = 3'd0, OP_ST = 3'd1, OP_FL = 3'd2,
                           OP_LS = 3'd4, OP_SS = 3'd5;
`ifdef L2_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic valid; logic [0:0] core; logic [1:0] unit; logic [1:0] strand;
        logic [2:0] op; logic [1:0] way; logic [25:0] addr; logic [511:0] data;
        logic [63:0] mask; logic has_sm; logic [511:0] sm_data;
        logic [1:0] hit_way; logic [1:0] repl_way; logic [1:0] fill_way;
        logic hit; logic [17:0] old_tag; logic [3:0] dirty;
        logic [1:0] l1_has; logic [3:0] l1_way;
    } req_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    l2_cache_read_stage_if bus ();
    l2_cache_read_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic         res_v [8];
    logic [25:0]  res_a [8];
    logic [511:0] mem_m [logic [9:0]];
    req_t         exp_r;
    logic         exp_succ, exp_dirty, mem_known;
    logic [511:0] exp_mem;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [136:0] ctl(input req_t r);
        return {r.valid, r.core, r.unit, r.strand, r.op, r.way, r.addr, r.mask, r.has_sm,
                r.hit_way, r.repl_way, r.fill_way, r.hit, r.old_tag, r.dirty, r.l1_has, r.l1_way};
    endfunction

    function automatic req_t get_obs();
        req_t o;
        o.valid = bus.rd_l2req_valid;     o.core = bus.rd_l2req_core;
        o.unit = bus.rd_l2req_unit;       o.strand = bus.rd_l2req_strand;
        o.op = bus.rd_l2req_op;           o.way = bus.rd_l2req_way;
        o.addr = bus.rd_l2req_address;    o.data = bus.rd_l2req_data;
        o.mask = bus.rd_l2req_mask;       o.has_sm = bus.rd_has_sm_data;
        o.sm_data = bus.rd_sm_data;       o.hit_way = bus.rd_hit_l2_way;
        o.repl_way = bus.rd_replace_l2_way; o.fill_way = bus.rd_sm_fill_way;
        o.hit = bus.rd_cache_hit;         o.old_tag = bus.rd_old_l2_tag;
        o.dirty = bus.rd_l2_dirty;        o.l1_has = bus.rd_l1_has_line;
        o.l1_way = bus.rd_l1_way;
        return o;
    endfunction

    task automatic drive(input logic st, input req_t r, input logic we,
                         input logic [9:0] widx, input logic [511:0] wd);
        bus.stall_pipeline = st;
        bus.dir_l2req_valid = r.valid;   bus.dir_l2req_core = r.core;
        bus.dir_l2req_unit = r.unit;     bus.dir_l2req_strand = r.strand;
        bus.dir_l2req_op = r.op;         bus.dir_l2req_way = r.way;
        bus.dir_l2req_address = r.addr;  bus.dir_l2req_data = r.data;
        bus.dir_l2req_mask = r.mask;     bus.dir_has_sm_data = r.has_sm;
        bus.dir_sm_data = r.sm_data;     bus.dir_hit_l2_way = r.hit_way;
        bus.dir_replace_l2_way = r.repl_way; bus.dir_sm_fill_way = r.fill_way;
        bus.dir_cache_hit = r.hit;       bus.dir_old_l2_tag = r.old_tag;
        bus.dir_l2_dirty = r.dirty;      bus.dir_l1_has_line = r.l1_has;
        bus.dir_l1_way = r.l1_way;
        bus.wr_update_l2_data = we;      bus.wr_cache_write_index = widx;
        bus.wr_update_data = wd;
    endtask

    function automatic void clear_res(input logic [25:0] a);
        for (int i = 0; i < 8; i++) if (res_a[i] == a) res_v[i] = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin res_v[i] = 1'b0; res_a[i] = '1; end
        exp_r = '0; exp_succ = 1'b0; exp_dirty = 1'b0; exp_mem = '0; mem_known = 1'b1;
    endfunction

    task automatic check_outputs(input string pfx);
        req_t o;
        o = get_obs();
        chk({pfx, "_ctl"},     512'(ctl(o)), 512'(ctl(exp_r)));
        chk({pfx, "_data"},    o.data, exp_r.data);
        chk({pfx, "_smdata"},  o.sm_data, exp_r.sm_data);
        chk({pfx, "_dirty"},   512'(bus.rd_line_is_dirty), 512'(exp_dirty));
        chk({pfx, "_syncok"},  512'(bus.rd_store_sync_success), 512'(exp_succ));
        if (mem_known) chk({pfx, "_memres"}, bus.rd_cache_mem_result, exp_mem);
    endtask

    // One clock: apply inputs, advance the model, check after the edge.
    task automatic step(input logic st, input req_t r, input logic we,
                        input logic [9:0] widx, input logic [511:0] wd);
        logic [9:0] ridx;
        int g;
        logic ok;
        drive(st, r, we, widx, wd);
        if (!st) begin
            ridx = {r.hit ? r.hit_way : r.fill_way, r.addr[7:0]};
            g = int'(r.core) * 4 + int'(r.strand);
            ok = 1'b0;
            if (r.valid) begin
                if (r.op == OP_LS) begin res_v[g] = 1'b1; res_a[g] = r.addr; end
                else if (r.op == OP_ST) clear_res(r.addr);
                else if (r.op == OP_SS) begin
                    ok = res_v[g] && (res_a[g] == r.addr);
                    if (ok) clear_res(r.addr);
                end
                if (!r.hit && r.has_sm) clear_res({r.old_tag, r.addr[7:0]});
                if (BYP && we && widx == ridx) begin exp_mem = wd; mem_known = 1'b1; end
                else if (mem_m.exists(ridx)) begin exp_mem = mem_m[ridx]; mem_known = 1'b1; end
                else mem_known = 1'b0;
            end else begin
                exp_mem = '0; mem_known = 1'b1;
            end
            exp_succ  = ok;
            exp_dirty = r.dirty[(r.op == OP_FL) ? r.hit_way : r.fill_way];
            if (we) mem_m[widx] = wd;
            exp_r = r;
        end
        @(posedge clk);
        #1;
        check_outputs(st ? "stall" : "step");
    endtask

    function automatic req_t mk(input logic c, input logic [1:0] s, input logic [2:0] op,
                                input logic [25:0] a);
        req_t r;
        r = '0;
        r.valid = 1'b1; r.core = c; r.strand = s; r.op = op; r.addr = a; r.hit = 1'b1;
        r.unit = 2'($urandom); r.data = rnd512(); r.mask = {$urandom, $urandom};
        r.l1_has = 2'($urandom); r.l1_way = 4'($urandom);
        return r;
    endfunction

    logic [25:0] pool [6] = '{26'h00145, 26'h00245, 26'h00345, 26'h001A0, 26'h002A0, 26'h003A0};
    logic [7:0]  sets [2] = '{8'h45, 8'hA0};
    logic [17:0] tags [4] = '{18'h1, 18'h2, 18'h3, 18'h5};

    function automatic req_t rand_req();
        req_t r;
        r = mk(1'($urandom), 2'($urandom), 3'($urandom_range(0, 5)), pool[$urandom_range(0, 5)]);
        r.valid = ($urandom_range(0, 99) < 85);
        r.hit = 1'($urandom); r.has_sm = 1'($urandom); r.sm_data = rnd512();
        r.way = 2'($urandom); r.hit_way = 2'($urandom); r.repl_way = 2'($urandom);
        r.fill_way = 2'($urandom); r.old_tag = tags[$urandom_range(0, 3)];
        r.dirty = 4'($urandom);
        return r;
    endfunction

    initial begin
        req_t r;
        logic [511:0] oldd, newd;
        logic [9:0] widx;

        model_reset();
        drive(1'b0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset_n = 1'b1;

        // Preload every index the stimulus will read.
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 2; s++)
                step(1'b0, '0, 1'b1, {2'(w), sets[s]}, rnd512());
        step(1'b0, '0, 1'b0, '0, '0);

        // g5 reserves then stores twice
        step(1'b0, mk(1'b1, 2'd1, OP_LS, 26'h12345), 1'b0, '0, '0);
        step(1'b0, mk(1'b1, 2'd1, OP_SS, 26'h12345), 1'b0, '0, '0);
        chk("g5_ss_first", 512'(bus.rd_store_sync_success), 512'(1'b1));
        step(1'b0, mk(1'b1, 2'd1, OP_SS, 26'h12345), 1'b0, '0, '0);
        chk("g5_ss_second", 512'(bus.rd_store_sync_success), 512'(1'b0));

        // Plain STORE from another strand kills g1's reservation
        step(1'b0, mk(1'b0, 2'd1, OP_LS, 26'h002A0), 1'b0, '0, '0);
        step(1'b0, mk(1'b0, 2'd2, OP_ST, 26'h002A0), 1'b0, '0, '0);
        step(1'b0, mk(1'b0, 2'd1, OP_SS, 26'h002A0), 1'b0, '0, '0);
        chk("g1_ss_after_store", 512'(bus.rd_store_sync_success), 512'(1'b0));

        // Failed STORE_SYNC from g3 leaves g4 intact
        step(1'b0, mk(1'b1, 2'd0, OP_LS, 26'h002A0), 1'b0, '0, '0);
        step(1'b0, mk(1'b0, 2'd3, OP_SS, 26'h002A0), 1'b0, '0, '0);
        chk("g3_ss_fail", 512'(bus.rd_store_sync_success), 512'(1'b0));
        step(1'b0, mk(1'b1, 2'd0, OP_SS, 26'h002A0), 1'b0, '0, '0);
        chk("g4_ss_kept", 512'(bus.rd_store_sync_success), 512'(1'b1));

        // Stall three cycles with a LOAD_SYNC (and a write) presented
        step(1'b0, mk(1'b0, 2'd0, OP_LD, 26'h002A0), 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(1'b1, 2'd2, OP_LS, 26'h00345), 1'b1, 10'h045, rnd512());
            chk("stall_addr_frozen", 512'(bus.rd_l2req_address), 512'(26'h002A0));
        end
        step(1'b0, mk(1'b1, 2'd2, OP_LD, 26'h00345), 1'b0, '0, '0);
        chk("stall_release_op", 512'(bus.rd_l2req_op), 512'(OP_LD));
        step(1'b0, mk(1'b1, 2'd2, OP_SS, 26'h00345), 1'b0, '0, '0);
        chk("stall_no_reserve", 512'(bus.rd_store_sync_success), 512'(1'b0));

        // Miss fill evicting victim B kills g0's reservation on B
        step(1'b0, mk(1'b0, 2'd0, OP_LS, 26'h00145), 1'b0, '0, '0);
        r = mk(1'b1, 2'd3, OP_LD, 26'h00345);
        r.hit = 1'b0; r.has_sm = 1'b1; r.old_tag = 18'h1; r.fill_way = 2'd3; r.sm_data = rnd512();
        step(1'b0, r, 1'b0, '0, '0);
        step(1'b0, mk(1'b0, 2'd0, OP_SS, 26'h00145), 1'b0, '0, '0);
        chk("evict_kill", 512'(bus.rd_store_sync_success), 512'(1'b0));

        // Dirty way select
        r = mk(1'b0, 2'd0, OP_FL, 26'h00345);
        r.hit_way = 2'd2; r.dirty = 4'b0100;
        step(1'b0, r, 1'b0, '0, '0);
        chk("flush_dirty", 512'(bus.rd_line_is_dirty), 512'(1'b1));
        r = mk(1'b0, 2'd0, OP_LD, 26'h00345);
        r.hit = 1'b0; r.fill_way = 2'd1; r.dirty = 4'b0100;
        step(1'b0, r, 1'b0, '0, '0);
        chk("miss_dirty", 512'(bus.rd_line_is_dirty), 512'(1'b0));

        // Same-index read and write
        oldd = mem_m[10'h045];
        newd = rnd512();
        step(1'b0, mk(1'b0, 2'd0, OP_LD, 26'h12345), 1'b1, 10'h045, newd);
        chk("rdw_same_idx", bus.rd_cache_mem_result, BYP ? newd : oldd);
        step(1'b0, mk(1'b0, 2'd0, OP_LD, 26'h12345), 1'b0, '0, '0);
        chk("read_after_write", bus.rd_cache_mem_result, newd);

        // Asynchronous reset mid-stream drops requests and reservations
        step(1'b0, mk(1'b1, 2'd3, OP_LS, 26'h00145), 1'b0, '0, '0);
        step(1'b0, mk(1'b0, 2'd0, OP_LD, 26'h002A0), 1'b0, '0, '0);
        drive(1'b0, mk(1'b0, 2'd1, OP_LD, 26'h002A0), 1'b0, '0, '0);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_outputs("async_reset");
        #2;
        reset_n = 1'b1;
        step(1'b0, mk(1'b1, 2'd3, OP_SS, 26'h00145), 1'b0, '0, '0);
        chk("reset_drops_resv", 512'(bus.rd_store_sync_success), 512'(1'b0));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = rand_req();
            if ($urandom_range(0, 99) < 40) widx = {r.hit ? r.hit_way : r.fill_way, r.addr[7:0]};
            else widx = {2'($urandom), sets[$urandom_range(0, 1)]};
            step($urandom_range(0, 99) < 15, r, 1'($urandom), widx, rnd512());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
